// File: rtl/mem_access_unit_if.sv
// Request, RAM and response signals of the memory-access unit.
// slave: the unit itself; master: the pipeline and RAM that surround it.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [3:0]            op;
    logic [31:0]           base;
    logic [15:0]           offset;
    logic [31:0]           store_data;
    logic [4:0]            rd_in;

    logic                  ram_req;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [3:0]            ram_sel;
    logic [31:0]           ram_wdata;
    logic                  ram_ack;
    logic [31:0]           ram_rdata;

    logic                  resp_valid;
    logic                  resp_we;
    logic [4:0]            resp_rd;
    logic [31:0]           resp_data;
    logic                  misalign_err;
    logic                  stall;

    modport slave (
        input  req_valid, op, base, offset, store_data, rd_in, ram_ack, ram_rdata,
        output req_ready, ram_req, ram_we, ram_addr, ram_sel, ram_wdata,
               resp_valid, resp_we, resp_rd, resp_data, misalign_err, stall
    );

    modport master (
        output req_valid, op, base, offset, store_data, rd_in, ram_ack, ram_rdata,
        input  req_ready, ram_req, ram_we, ram_addr, ram_sel, ram_wdata,
               resp_valid, resp_we, resp_rd, resp_data, misalign_err, stall
    );
endinterface

// File: rtl/mem_access_unit.sv
// Sequential load/store unit: one request at a time, word-wide handshaked RAM port,
// straddling accesses split into two transactions or rejected with misalign_err.
module mem_access_unit #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter bit          SPLIT_UNALIGNED = 1'b1
) (
    input logic            clk,
    input logic            rst,
    mem_access_unit_if.slave bus
);
    localparam int unsigned AW = ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

    function automatic logic [2:0] op_size(input logic [3:0] o);
        case (o)
            4'd1, 4'd2, 4'd9:  op_size = 3'd1;
            4'd3, 4'd4, 4'd10: op_size = 3'd2;
            4'd5, 4'd11:       op_size = 3'd4;
            default:           op_size = 3'd0;
        endcase
    endfunction

    function automatic logic is_load(input logic [3:0] o);
        is_load = (o >= 4'd1) && (o <= 4'd5);
    endfunction

    function automatic logic is_store(input logic [3:0] o);
        is_store = (o >= 4'd9) && (o <= 4'd11);
    endfunction

    function automatic logic straddles(input logic [1:0] ofs, input logic [2:0] sz);
        straddles = ({2'b00, ofs} + {1'b0, sz}) > 4'd4;
    endfunction

    state_e        state_q, state_d;
    logic [AW-1:0] ea_q, ea_d;
    logic [3:0]    op_q, op_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   sd_q, sd_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   hi_q, hi_d;
    logic          err_q, err_d;

    logic [31:0]   ea_sum;
    logic [AW-1:0] ea_in;
    logic [2:0]    size_in;
    logic [2:0]    size_q;
    logic          straddle_q;
    logic [4:0]    size_onehot;
    logic [3:0]    mask4;
    logic [7:0]    mask8;
    logic [63:0]   sh;
    logic [31:0]   ld;
    logic [31:0]   ld_ext;
    logic [AW-1:0] word0;
    logic [AW-1:0] word1;

    assign ea_sum  = bus.base + {{16{bus.offset[15]}}, bus.offset};
    assign ea_in   = ea_sum[AW-1:0];
    assign size_in = op_size(bus.op);

    assign size_q      = op_size(op_q);
    assign straddle_q  = straddles(ea_q[1:0], size_q);
    assign size_onehot = 5'd1 << size_q;
    assign mask4       = 4'(size_onehot - 5'd1);
    // 8-lane view spans both words; the upper nibble is the second transaction
    assign mask8       = {4'b0000, mask4} << ea_q[1:0];
    assign sh          = {32'h0, sd_q} << {ea_q[1:0], 3'b000};
    assign ld          = 32'({hi_q, lo_q} >> {ea_q[1:0], 3'b000});
    assign word0       = {ea_q[AW-1:2], 2'b00};
    assign word1       = word0 + AW'(4);

    always_comb begin
        case (op_q)
            4'd1:    ld_ext = {{24{ld[7]}}, ld[7:0]};
            4'd2:    ld_ext = {24'h0, ld[7:0]};
            4'd3:    ld_ext = {{16{ld[15]}}, ld[15:0]};
            4'd4:    ld_ext = {16'h0, ld[15:0]};
            default: ld_ext = ld;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ea_q    <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            sd_q    <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ea_q    <= ea_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            sd_q    <= sd_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ea_d    = ea_q;
        op_d    = op_q;
        rd_d    = rd_q;
        sd_d    = sd_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                // NOP-class codes are consumed here without ever leaving IDLE
                if (bus.req_valid && (size_in != 3'd0)) begin
                    ea_d    = ea_in;
                    op_d    = bus.op;
                    rd_d    = bus.rd_in;
                    sd_d    = bus.store_data;
                    lo_d    = '0;
                    hi_d    = '0;
                    err_d   = straddles(ea_in[1:0], size_in) && !SPLIT_UNALIGNED;
                    state_d = err_d ? RESP : ACC0;
                end
            end
            ACC0: begin
                if (bus.ram_ack) begin
                    lo_d    = bus.ram_rdata;
                    state_d = straddle_q ? ACC1 : RESP;
                end
            end
            ACC1: begin
                if (bus.ram_ack) begin
                    hi_d    = bus.ram_rdata;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready    = (state_q == IDLE);
        bus.stall        = (state_q != IDLE);
        bus.ram_req      = 1'b0;
        bus.ram_we       = 1'b0;
        bus.ram_addr     = '0;
        bus.ram_sel      = '0;
        bus.ram_wdata    = '0;
        bus.resp_valid   = 1'b0;
        bus.resp_we      = 1'b0;
        bus.resp_rd      = '0;
        bus.resp_data    = '0;
        bus.misalign_err = 1'b0;
        unique case (state_q)
            ACC0: begin
                bus.ram_req   = 1'b1;
                bus.ram_we    = is_store(op_q);
                bus.ram_addr  = word0;
                bus.ram_sel   = mask8[3:0];
                bus.ram_wdata = sh[31:0];
            end
            ACC1: begin
                bus.ram_req   = 1'b1;
                bus.ram_we    = is_store(op_q);
                bus.ram_addr  = word1;
                bus.ram_sel   = mask8[7:4];
                bus.ram_wdata = sh[63:32];
            end
            RESP: begin
                bus.resp_valid   = 1'b1;
                bus.resp_we      = is_load(op_q) && !err_q;
                bus.resp_rd      = rd_q;
                bus.resp_data    = (is_load(op_q) && !err_q) ? ld_ext : 32'h0;
                bus.misalign_err = err_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a byte-level memory model.
module tb_mem_access_unit;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_access_unit_if #(.ADDR_WIDTH(32)) bus_a ();
    mem_access_unit_if #(.ADDR_WIDTH(32)) bus_b ();

    mem_access_unit #(.ADDR_WIDTH(32), .SPLIT_UNALIGNED(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    mem_access_unit #(.ADDR_WIDTH(32), .SPLIT_UNALIGNED(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic        we;
    } txn_t;

    logic [31:0] ram_a [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    txn_t        log_a [$];
    bit          en_a = 1'b1;
    int unsigned wait_a = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return ((a & ~32'h3) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        logic [31:0] w;
        w = init_word(a) >> (8 * a[1:0]);
        return w[7:0];
    endfunction

    function automatic logic [31:0] ram_read_a(input logic [31:0] a);
        return ram_a.exists(a) ? ram_a[a] : init_word(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic int op_size_m(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd9:  return 1;
            4'd3, 4'd4, 4'd10: return 2;
            4'd5, 4'd11:       return 4;
            default:           return 0;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [3:0] op, input logic [31:0] d);
        case (op)
            4'd1:    return 32'($signed(d[7:0]));
            4'd2:    return {24'h0, d[7:0]};
            4'd3:    return 32'($signed(d[15:0]));
            4'd4:    return {16'h0, d[15:0]};
            4'd5:    return d;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{sel[i]}};
        return m;
    endfunction

    task automatic poke_word(input logic [31:0] addr, input logic [31:0] val);
        ram_a[addr] = val;
        for (int i = 0; i < 4; i++) ref_mem[addr + 32'(i)] = val[8*i +: 8];
    endtask

    // RAM behind DUT A: acks after wait_a idle request cycles, applies byte-enabled writes
    initial begin : ram_a_model
        int unsigned cnt;
        logic [31:0] w;
        txn_t t;
        cnt = 0;
        bus_a.ram_ack   = 1'b0;
        bus_a.ram_rdata = '0;
        forever begin
            @(negedge clk);
            if (en_a) begin
                bus_a.ram_ack   = 1'b0;
                bus_a.ram_rdata = $urandom;
                if (bus_a.ram_req) begin
                    if (cnt >= wait_a) begin
                        cnt = 0;
                        w = ram_read_a(bus_a.ram_addr);
                        bus_a.ram_ack   = 1'b1;
                        bus_a.ram_rdata = w;
                        t.addr = bus_a.ram_addr; t.sel = bus_a.ram_sel;
                        t.wdata = bus_a.ram_wdata; t.we = bus_a.ram_we;
                        log_a.push_back(t);
                        if (bus_a.ram_we) begin
                            for (int i = 0; i < 4; i++)
                                if (bus_a.ram_sel[i]) w[8*i +: 8] = bus_a.ram_wdata[8*i +: 8];
                            ram_a[bus_a.ram_addr] = w;
                        end
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // RAM behind DUT B: read-only, immediate ack
    initial begin : ram_b_model
        bus_b.ram_ack   = 1'b0;
        bus_b.ram_rdata = '0;
        forever begin
            @(negedge clk);
            bus_b.ram_ack   = bus_b.ram_req;
            bus_b.ram_rdata = init_word(bus_b.ram_addr);
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [31:0] base, input logic [15:0] off,
                          input logic [31:0] sd, input logic [4:0] rd, input int unsigned w);
        logic [31:0] ea, a, d, exp_data;
        int sz, n, lat, exp_lat, k, wi;
        txn_t exp_q [$];
        txn_t cur;
        bit seen;
        ea = base + {{16{off[15]}}, off};
        sz = op_size_m(op);
        wi = int'(w);
        d  = '0;
        cur.addr = '0; cur.sel = '0; cur.wdata = '0; cur.we = 1'b0;
        for (int i = 0; i < sz; i++) begin
            a = ea + 32'(i);
            if (i == 0 || {a[31:2], 2'b00} != cur.addr) begin
                if (i != 0) exp_q.push_back(cur);
                cur.addr = {a[31:2], 2'b00}; cur.sel = '0; cur.wdata = '0; cur.we = (op >= 4'd9);
            end
            cur.sel[a[1:0]] = 1'b1;
            cur.wdata[8*a[1:0] +: 8] = sd[8*i +: 8];
            d[8*i +: 8] = ref_byte(a);
            if (op >= 4'd9) ref_mem[a] = sd[8*i +: 8];
        end
        if (sz != 0) exp_q.push_back(cur);
        exp_data = extend(op, d);
        n = exp_q.size();
        exp_lat = n * (wi + 1) + 1;

        wait_a = w;
        log_a.delete();
        k = 0;
        @(negedge clk);
        while (!bus_a.req_ready && k < 20) begin @(negedge clk); k++; end
        total++;
        if (k >= 20) begin bad++; $display("FAIL ready_timeout: req_ready stayed low"); return; end
        bus_a.req_valid = 1'b1; bus_a.op = op; bus_a.base = base; bus_a.offset = off;
        bus_a.store_data = sd; bus_a.rd_in = rd;
        @(posedge clk);
        @(negedge clk);
        bus_a.req_valid = 1'b0;

        if (sz == 0) begin
            for (int c = 0; c < 3; c++) begin
                total++;
                if (bus_a.resp_valid !== 1'b0 || bus_a.ram_req !== 1'b0 || bus_a.req_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL nop op=%0d: resp_valid=%b ram_req=%b req_ready=%b want 0 0 1",
                             op, bus_a.resp_valid, bus_a.ram_req, bus_a.req_ready);
                end
                @(negedge clk);
            end
            return;
        end

        lat = 1; seen = 0;
        while (lat <= 40) begin
            if (bus_a.resp_valid === 1'b1) begin seen = 1; break; end
            total++;
            if (bus_a.stall !== 1'b1) begin bad++; $display("FAIL stall: got %b want 1 cycle %0d", bus_a.stall, lat); end
            if (lat <= n * (wi + 1)) begin
                k = (lat - 1) / (wi + 1);
                total++;
                if (bus_a.ram_req !== 1'b1) begin bad++; $display("FAIL ram_req: got %b want 1 cycle %0d", bus_a.ram_req, lat); end
                total++;
                if (bus_a.ram_addr !== exp_q[k].addr) begin bad++; $display("FAIL ram_addr: got %h want %h cycle %0d", bus_a.ram_addr, exp_q[k].addr, lat); end
                total++;
                if (bus_a.ram_sel !== exp_q[k].sel) begin bad++; $display("FAIL ram_sel: got %b want %b cycle %0d", bus_a.ram_sel, exp_q[k].sel, lat); end
                total++;
                if (bus_a.ram_we !== exp_q[k].we) begin bad++; $display("FAIL ram_we: got %b want %b", bus_a.ram_we, exp_q[k].we); end
                if (exp_q[k].we) begin
                    total++;
                    if ((bus_a.ram_wdata & lane_mask(exp_q[k].sel)) !== exp_q[k].wdata) begin
                        bad++;
                        $display("FAIL ram_wdata: got %h want %h (sel %b)", bus_a.ram_wdata, exp_q[k].wdata, exp_q[k].sel);
                    end
                end
            end
            @(negedge clk);
            lat++;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL resp_timeout: op=%0d ea=%h no resp_valid", op, ea); return; end
        total++;
        if (lat != exp_lat) begin bad++; $display("FAIL latency: got %0d want %0d", lat, exp_lat); end
        total++;
        if (bus_a.resp_data !== exp_data) begin bad++; $display("FAIL resp_data: op=%0d ea=%h got %h want %h", op, ea, bus_a.resp_data, exp_data); end
        total++;
        if (bus_a.resp_we !== (op <= 4'd5)) begin bad++; $display("FAIL resp_we: got %b want %b", bus_a.resp_we, (op <= 4'd5)); end
        total++;
        if (bus_a.resp_rd !== rd) begin bad++; $display("FAIL resp_rd: got %0d want %0d", bus_a.resp_rd, rd); end
        total++;
        if (bus_a.misalign_err !== 1'b0 || bus_a.ram_req !== 1'b0 || bus_a.req_ready !== 1'b0) begin
            bad++;
            $display("FAIL resp_cycle: err=%b ram_req=%b req_ready=%b want 0 0 0", bus_a.misalign_err, bus_a.ram_req, bus_a.req_ready);
        end
        total++;
        if (log_a.size() != n) begin bad++; $display("FAIL txn_count: got %0d want %0d", log_a.size(), n); end
        @(negedge clk);
        total++;
        if (bus_a.resp_valid !== 1'b0 || bus_a.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL resp_pulse: resp_valid=%b req_ready=%b want 0 1", bus_a.resp_valid, bus_a.req_ready);
        end
    endtask

    task automatic run_b(input logic [3:0] op, input logic [31:0] base, input logic [15:0] off, input logic [4:0] rd);
        logic [31:0] ea, d, exp_data;
        int sz, lat, exp_lat;
        bit err, seen, saw_req;
        ea = base + {{16{off[15]}}, off};
        sz = op_size_m(op);
        d  = '0;
        for (int i = 0; i < sz; i++) d[8*i +: 8] = init_byte(ea + 32'(i));
        err      = ((ea + 32'(sz - 1)) >> 2) != (ea >> 2);
        exp_data = err ? 32'h0 : extend(op, d);
        exp_lat  = err ? 1 : 2;
        @(negedge clk);
        bus_b.req_valid = 1'b1; bus_b.op = op; bus_b.base = base; bus_b.offset = off; bus_b.rd_in = rd;
        @(posedge clk);
        @(negedge clk);
        bus_b.req_valid = 1'b0;
        lat = 1; seen = 0; saw_req = 0;
        while (lat <= 20) begin
            if (bus_b.ram_req === 1'b1) saw_req = 1;
            if (bus_b.resp_valid === 1'b1) begin seen = 1; break; end
            @(negedge clk);
            lat++;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL b_timeout: ea=%h no resp_valid", ea); return; end
        total++;
        if (lat != exp_lat) begin bad++; $display("FAIL b_latency: ea=%h got %0d want %0d", ea, lat, exp_lat); end
        total++;
        if (saw_req !== !err) begin bad++; $display("FAIL b_ram_req: ea=%h seen=%b want %b", ea, saw_req, !err); end
        total++;
        if (bus_b.misalign_err !== err) begin bad++; $display("FAIL b_misalign_err: got %b want %b", bus_b.misalign_err, err); end
        total++;
        if (bus_b.resp_we !== !err) begin bad++; $display("FAIL b_resp_we: got %b want %b", bus_b.resp_we, !err); end
        total++;
        if (bus_b.resp_data !== exp_data) begin bad++; $display("FAIL b_resp_data: got %h want %h", bus_b.resp_data, exp_data); end
        total++;
        if (bus_b.resp_rd !== rd) begin bad++; $display("FAIL b_resp_rd: got %0d want %0d", bus_b.resp_rd, rd); end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus_a.req_ready !== 1'b1 || bus_a.stall !== 1'b0 || bus_a.ram_req !== 1'b0 || bus_a.ram_we !== 1'b0 ||
            bus_a.ram_addr !== 32'h0 || bus_a.ram_sel !== 4'h0 || bus_a.ram_wdata !== 32'h0 || bus_a.resp_valid !== 1'b0 ||
            bus_a.resp_we !== 1'b0 || bus_a.resp_rd !== 5'h0 || bus_a.resp_data !== 32'h0 || bus_a.misalign_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_a: ready=%b stall=%b req=%b addr=%h sel=%b resp_valid=%b data=%h want 1 0 0 0 0 0 0",
                     bus_a.req_ready, bus_a.stall, bus_a.ram_req, bus_a.ram_addr, bus_a.ram_sel, bus_a.resp_valid, bus_a.resp_data);
        end
        total++;
        if (bus_b.req_ready !== 1'b1 || bus_b.ram_req !== 1'b0 || bus_b.resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_b: ready=%b req=%b resp_valid=%b want 1 0 0", bus_b.req_ready, bus_b.ram_req, bus_b.resp_valid);
        end
        rst = 1'b1;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        en_a = 1'b0;
        bus_a.ram_ack = 1'b0;
        bus_a.req_valid = 1'b1; bus_a.op = 4'd5; bus_a.base = 32'h100; bus_a.offset = 16'h4; bus_a.rd_in = 5'd9;
        @(posedge clk);
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        total++;
        if (bus_a.ram_req !== 1'b1) begin bad++; $display("FAIL mid_req: got %b want 1", bus_a.ram_req); end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (bus_a.ram_req !== 1'b0 || bus_a.resp_valid !== 1'b0 || bus_a.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: req=%b resp_valid=%b ready=%b want 0 0 1", bus_a.ram_req, bus_a.resp_valid, bus_a.req_ready);
        end
        rst = 1'b1;
        bus_a.ram_ack = 1'b1;
        bus_a.ram_rdata = 32'hCAFE_F00D;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (bus_a.ram_req !== 1'b0 || bus_a.resp_valid !== 1'b0 || bus_a.req_ready !== 1'b1) begin
                bad++;
                $display("FAIL late_ack: req=%b resp_valid=%b ready=%b want 0 0 1", bus_a.ram_req, bus_a.resp_valid, bus_a.req_ready);
            end
        end
        bus_a.ram_ack = 1'b0;
        en_a = 1'b1;
    endtask

    task automatic test_aligned();
        poke_word(32'h104, 32'hDEAD_BEEF);
        run_op(4'd5, 32'h100, 16'h0004, 32'h0, 5'd3, 0);
        run_op(4'd11, 32'h200, 16'h0010, 32'h1122_3344, 5'd0, 0);
        run_op(4'd5, 32'h208, 16'hFFF8, 32'h0, 5'd6, 0);
    endtask

    task automatic test_byte_ops();
        run_op(4'd9, 32'h200, 16'h0003, 32'h0000_00A5, 5'd0, 0);
        poke_word(32'h200, 32'h8000_0000);
        run_op(4'd1, 32'h200, 16'h0003, 32'h0, 5'd4, 0);
        run_op(4'd2, 32'h200, 16'h0003, 32'h0, 5'd5, 0);
        run_op(4'd3, 32'h200, 16'h0002, 32'h0, 5'd7, 0);
        run_op(4'd4, 32'h200, 16'h0002, 32'h0, 5'd8, 0);
        run_op(4'd10, 32'h300, 16'h0002, 32'h0000_1234, 5'd0, 0);
    endtask

    task automatic test_split();
        poke_word(32'h1000, 32'h4433_2211);
        poke_word(32'h1004, 32'h8877_6655);
        run_op(4'd5, 32'h1000, 16'h0002, 32'h0, 5'd10, 0);
        run_op(4'd10, 32'h0, 16'h0007, 32'h0000_BEEF, 5'd0, 0);
        run_op(4'd4, 32'h0, 16'h0007, 32'h0, 5'd11, 0);
        run_op(4'd5, 32'hFFFF_FFF0, 16'h000E, 32'h0, 5'd12, 0);
        run_op(4'd11, 32'h0000_0004, 16'hFFFD, 32'hA1B2_C3D4, 5'd0, 0);
    endtask

    task automatic test_wait_states();
        run_op(4'd11, 32'h400, 16'h0004, 32'h1234_5678, 5'd0, 3);
        run_op(4'd3, 32'h400, 16'h0007, 32'h0, 5'd13, 3);
        run_op(4'd10, 32'h500, 16'h0003, 32'h0000_9ABC, 5'd0, 2);
    endtask

    task automatic test_nop();
        run_op(4'd0, 32'h100, 16'h0, 32'h0, 5'd1, 0);
        run_op(4'd7, 32'h100, 16'h0, 32'h0, 5'd1, 0);
        run_op(4'd15, 32'h100, 16'h0, 32'h0, 5'd1, 0);
    endtask

    task automatic test_misalign_reject();
        run_b(4'd5, 32'h0, 16'h0001, 5'd7);
        run_b(4'd3, 32'h0, 16'h0003, 5'd8);
        run_b(4'd4, 32'h0, 16'h0002, 5'd9);
        run_b(4'd5, 32'h50, 16'h0000, 5'd10);
        run_b(4'd1, 32'h50, 16'h0003, 5'd11);
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [11];
        logic [31:0] base;
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd6, 4'd13};
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) base = 32'hFFFF_FFF8;
            else base = 32'h3000 + 32'($urandom_range(0, 31));
            run_op(ops[$urandom_range(0, 10)], base, 16'($urandom_range(0, 32)) - 16'd16,
                   $urandom, 5'($urandom), $urandom_range(0, 2));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus_a.req_valid = 1'b0; bus_a.op = '0; bus_a.base = '0; bus_a.offset = '0;
        bus_a.store_data = '0; bus_a.rd_in = '0;
        bus_b.req_valid = 1'b0; bus_b.op = '0; bus_b.base = '0; bus_b.offset = '0;
        bus_b.store_data = '0; bus_b.rd_in = '0;
        test_reset();
        test_aligned();
        test_byte_ops();
        test_split();
        test_wait_states();
        test_nop();
        test_misalign_reject();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
